traditional_matrix_multiplier: RTL and testbench

//   Baseline sequential matrix multiplier: C[MxN] = A[MxK] * B[KxN], one multiply-accumulate per clock.

---
 rtl/traditional_matrix_multiplier.sv | 168 ++++++++++++++++
 tb/tb_traditional_matrix_multiplier.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/traditional_matrix_multiplier.sv
// ---------------------------------------------------------------------------
// traditional_matrix_multiplier
//
// Purpose:
//   Baseline sequential matrix multiplier computing C[MxN] = A[MxK] * B[KxN]
//   with one multiply-accumulate per clock. It is the reference block for the
//   systolic-array multiplier and shares its flattened-bus interface.
//
// Ports:
//   clk     in   1               single clock, rising edge
//   rst     in   1               asynchronous, active-high reset
//   start   in   1               begin a multiplication (honoured in IDLE/DONE)
//   A_flat  in   M*K*DATA_WIDTH  A row-major, A[i][j] at element i*K+j
//   B_flat  in   K*N*DATA_WIDTH  B row-major, B[i][j] at element i*N+j
//   C_flat  out  M*N*ACC_WIDTH   C row-major, C[i][j] at element i*N+j
//   done    out  1               result valid, held until next start or reset
//
// Configuration:
//   MM_SIGNED_EN  when defined, A/B/C are two's complement and products are
//                 sign-extended into the accumulator; otherwise unsigned.
// ---------------------------------------------------------------------------
module traditional_matrix_multiplier #(
  parameter int M          = 6,
  parameter int K          = 6,
  parameter int N          = 6,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [M*K*DATA_WIDTH-1:0]     A_flat,
  input  logic [K*N*DATA_WIDTH-1:0]     B_flat,
  output logic [M*N*ACC_WIDTH-1:0]      C_flat,
  output logic                          done
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2*DATA_WIDTH;

  localparam logic [IW-1:0] I_LAST = IW'(M-1);
  localparam logic [JW-1:0] J_LAST = JW'(N-1);
  localparam logic [KW-1:0] K_LAST = KW'(K-1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t                state;
  logic [IW-1:0]         i_idx;
  logic [JW-1:0]         j_idx;
  logic [KW-1:0]         k_idx;
  logic [ACC_WIDTH-1:0]  acc;

  // Operand snapshots taken at the start edge, so the inputs are free to
  // change while the multiplication runs.
  logic [DATA_WIDTH-1:0] a_mem [M][K];
  logic [DATA_WIDTH-1:0] b_mem [K][N];
  logic [ACC_WIDTH-1:0]  c_mem [M][N];

  logic [DATA_WIDTH-1:0] a_elem;
  logic [DATA_WIDTH-1:0] b_elem;
  logic [PW-1:0]         a_ext;
  logic [PW-1:0]         b_ext;
  logic [PW-1:0]         prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  acc_next;

  // The multiply is done at double width on pre-extended operands: the low
  // PW bits of that product are the correct result for both the signed and
  // unsigned builds, so only the extension into the accumulator differs.
  always_comb begin
    a_elem = a_mem[i_idx][k_idx];
    b_elem = b_mem[k_idx][j_idx];
`ifdef MM_SIGNED_EN
    a_ext    = {{DATA_WIDTH{a_elem[DATA_WIDTH-1]}}, a_elem};
    b_ext    = {{DATA_WIDTH{b_elem[DATA_WIDTH-1]}}, b_elem};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
`else
    a_ext    = {{DATA_WIDTH{1'b0}}, a_elem};
    b_ext    = {{DATA_WIDTH{1'b0}}, b_elem};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_WIDTH-PW){1'b0}}, prod};
`endif
    acc_next = acc + prod_ext;
  end

  // Control FSM and datapath. Loop order is i outer, j middle, k inner; the
  // finished dot product is written straight from acc_next on the last k so
  // no extra drain cycle is needed and done rises M*N*K edges after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      acc   <= '0;
      i_idx <= '0;
      j_idx <= '0;
      k_idx <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < K; c++)
          a_mem[r][c] <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < N; c++)
          b_mem[r][c] <= '0;
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          c_mem[r][c] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int r = 0; r < M; r++)
              for (int c = 0; c < K; c++)
                a_mem[r][c] <= A_flat[(r*K+c)*DATA_WIDTH +: DATA_WIDTH];
            for (int r = 0; r < K; r++)
              for (int c = 0; c < N; c++)
                b_mem[r][c] <= B_flat[(r*N+c)*DATA_WIDTH +: DATA_WIDTH];
            for (int r = 0; r < M; r++)
              for (int c = 0; c < N; c++)
                c_mem[r][c] <= '0;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
            k_idx <= '0;
            done  <= 1'b0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (k_idx == K_LAST) begin
            c_mem[i_idx][j_idx] <= acc_next;
            acc   <= '0;
            k_idx <= '0;
            if (j_idx == J_LAST) begin
              j_idx <= '0;
              if (i_idx == I_LAST) begin
                i_idx <= '0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                i_idx <= i_idx + 1'b1;
              end
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end else begin
            acc   <= acc_next;
            k_idx <= k_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The result bus is plain wiring from the C registers.
  for (genvar r = 0; r < M; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign C_flat[(r*N+c)*ACC_WIDTH +: ACC_WIDTH] = c_mem[r][c];
    end
  end

endmodule

// File: tb/tb_traditional_matrix_multiplier.sv
module tb_traditional_matrix_multiplier;

  localparam int M   = 6;
  localparam int K   = 6;
  localparam int N   = 6;
  localparam int DW  = 16;
  localparam int ACC = 2*DW + $clog2(K);
  localparam int CW  = M*N*ACC;
  localparam int LATENCY = M*N*K;
  localparam int BOUND   = 1000;

  logic              clk;
  logic              rst;
  logic              start;
  logic [M*K*DW-1:0] A_flat;
  logic [K*N*DW-1:0] B_flat;
  logic [CW-1:0]     C_flat;
  logic              done;

  traditional_matrix_multiplier #(
    .M(M), .K(K), .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(ACC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A_flat(A_flat),
    .B_flat(B_flat),
    .C_flat(C_flat),
    .done(done)
  );

  // 100 MHz-style free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int cyc;

  logic [DW-1:0] a_m [M][K];
  logic [DW-1:0] b_m [K][N];
  logic [CW-1:0] exp_q [$];
  logic [CW-1:0] last_exp;

  // Count one comparison and report it when observed and expected disagree
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [ACC-1:0] cElem(input logic [CW-1:0] v, input int r, input int c);
    return v[(r*N+c)*ACC +: ACC];
  endfunction

  // Reference model: plain triple loop in 64-bit arithmetic, truncated to ACC
  function automatic logic [CW-1:0] modelProduct();
    logic [CW-1:0] res;
    logic [63:0]   s;
    longint        sum;
    res = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        sum = 0;
        for (int x = 0; x < K; x++) begin
`ifdef MM_SIGNED_EN
          sum += longint'($signed(a_m[r][x])) * longint'($signed(b_m[x][c]));
`else
          sum += longint'(a_m[r][x]) * longint'(b_m[x][c]);
`endif
        end
        s = sum;
        res[(r*N+c)*ACC +: ACC] = s[ACC-1:0];
      end
    end
    return res;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive the current matrices, queue the model result and pulse start
  task automatic applyStimulus(input string name);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++)
        A_flat[(r*K+c)*DW +: DW] = a_m[r][c];
    for (int r = 0; r < K; r++)
      for (int c = 0; c < N; c++)
        B_flat[(r*N+c)*DW +: DW] = b_m[r][c];
    exp_q.push_back(modelProduct());
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    checkOutput({name, "_done_low_after_start"}, {63'd0, done}, 64'd0);
    checkOutput({name, "_c_cleared_after_start"}, {63'd0, |C_flat}, 64'd0);
  endtask

  // Bounded wait for done, then latency check and scoreboard compare
  task automatic waitAndCheck(input string name);
    while (!done && cyc < BOUND) stepCycle();
    checkOutput({name, "_done"}, {63'd0, done}, 64'd1);
    checkOutput({name, "_latency"}, 64'(cyc), 64'(LATENCY));
    if (exp_q.size() == 0) begin
      checkOutput({name, "_scoreboard_entry"}, 64'(exp_q.size()), 64'd1);
    end else begin
      last_exp = exp_q.pop_front();
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          checkOutput($sformatf("%s_C[%0d][%0d]", name, r, c),
                      64'(cElem(C_flat, r, c)), 64'(cElem(last_exp, r, c)));
    end
  endtask

  task automatic setPatternIj();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        a_m[r][c] = DW'(r + c + 1);
        b_m[r][c] = DW'(r + c + 1);
      end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A_flat = '0;
    B_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_c_zero", {63'd0, |C_flat}, 64'd0);

    // Test 1: A=B=i+j+1, known corner values
    setPatternIj();
    applyStimulus("ij");
    waitAndCheck("ij");
    checkOutput("ij_C00_const", 64'(cElem(C_flat, 0, 0)), 64'd91);
    checkOutput("ij_C01_const", 64'(cElem(C_flat, 0, 1)), 64'd112);
    checkOutput("ij_C10_const", 64'(cElem(C_flat, 1, 0)), 64'd112);
    checkOutput("ij_C55_const", 64'(cElem(C_flat, 5, 5)), 64'd451);
    repeat (5) stepCycle();
    checkOutput("ij_done_held", {63'd0, done}, 64'd1);
    checkOutput("ij_C55_held", 64'(cElem(C_flat, 5, 5)), 64'(cElem(last_exp, 5, 5)));

    // Test 2: identity times B gives B, then relaunch from DONE with zeros
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        a_m[r][c] = (r == c) ? DW'(1) : DW'(0);
        b_m[r][c] = DW'(r*6 + c);
      end
    applyStimulus("ident");
    waitAndCheck("ident");
    checkOutput("ident_C34_const", 64'(cElem(C_flat, 3, 4)), 64'd22);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        a_m[r][c] = '0;
        b_m[r][c] = '0;
      end
    applyStimulus("zero");
    waitAndCheck("zero");
    checkOutput("zero_all", {63'd0, |C_flat}, 64'd0);

    // Test 3: all-ones operands, largest sum without wrap
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        a_m[r][c] = 16'hFFFF;
        b_m[r][c] = 16'hFFFF;
      end
    applyStimulus("max");
    waitAndCheck("max");
`ifndef MM_SIGNED_EN
    checkOutput("max_C23_const", 64'(cElem(C_flat, 2, 3)), 64'd25769017350);
`endif

    // Test 4: reset in the middle of COMPUTE, then rerun test 1 data
    setPatternIj();
    applyStimulus("abort");
    repeat (100) stepCycle();
    rst = 1'b1;
    #1;
    checkOutput("abort_done_low", {63'd0, done}, 64'd0);
    checkOutput("abort_c_zero", {63'd0, |C_flat}, 64'd0);
    void'(exp_q.pop_back());
    stepCycle();
    rst = 1'b0;
    repeat (3) stepCycle();
    checkOutput("abort_stays_idle", {63'd0, done}, 64'd0);
    applyStimulus("rerun");
    waitAndCheck("rerun");
    checkOutput("rerun_C55_const", 64'(cElem(C_flat, 5, 5)), 64'd451);

    // Test 5: start toggling and input changes during COMPUTE are ignored
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        a_m[r][c] = DW'($urandom_range(0, 65535));
        b_m[r][c] = DW'($urandom_range(0, 65535));
      end
    applyStimulus("tamper");
    for (int t = 0; t < 60; t++) begin
      stepCycle();
      start  = ~start;
      A_flat = {M*K{16'($urandom)}};
      B_flat = {K*N{16'($urandom)}};
    end
    start = 1'b0;
    waitAndCheck("tamper");

`ifdef MM_SIGNED_EN
    // Test 6: signed build, -1 times 2 summed six times
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        a_m[r][c] = 16'hFFFF;
        b_m[r][c] = 16'd2;
      end
    applyStimulus("signed");
    waitAndCheck("signed");
    checkOutput("signed_C00_const", 64'(cElem(C_flat, 0, 0)), 64'(35'h7_FFFF_FFF4));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
